// File: rtl/normalizer_32_pkg.sv
// Shared constants and state encoding for the 32-bit normalizer.
// The signed (redundant-sign-bit) mode is built only when NORMALIZER_SIGNED_EN is defined.
package normalizer_32_pkg;

  localparam int WORD_W      = 32;
  localparam int NORM_STAGES = 5;
  localparam int CNT_W       = 6;
  localparam int K_W         = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/normalizer_32_if.sv
// Request/result bundle of the normalizer: start/x/arith in, busy/done/results out.
// arith only has an effect when NORMALIZER_SIGNED_EN is defined.
interface normalizer_32_if;
  import normalizer_32_pkg::*;

  logic              start;
  logic [WORD_W-1:0] x;
  logic              arith;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] sh;
  logic [CNT_W-1:0]  cnt;
  logic              zero;

  modport master (
    output start, x, arith,
    input  busy, done, sh, cnt, zero
  );

  modport slave (
    input  start, x, arith,
    output busy, done, sh, cnt, zero
  );

endinterface

// File: rtl/normalizer_32_stage.sv
// One binary-search stage of the normalizer, shared across all five stages.
// Tests the top 2^k bits (unsigned) or top 2^k+1 bits against bit 31 (signed)
// and shifts left by 2^k on a hit. Signed test exists only with NORMALIZER_SIGNED_EN.
module normalizer_32_stage
  import normalizer_32_pkg::*;
(
  input  logic [WORD_W-1:0] v,
  input  logic [K_W-1:0]    k,
  input  logic              m,
  output logic [WORD_W-1:0] v_next,
  output logic              hit
);

  logic [CNT_W-1:0]  amt;
  logic [WORD_W-1:0] top_mask;
  logic              hit_u;

  assign amt      = CNT_W'(1) << k;
  assign top_mask = ~({WORD_W{1'b1}} >> amt);
  assign hit_u    = ((v & top_mask) == '0);

`ifdef NORMALIZER_SIGNED_EN
  logic [WORD_W-1:0] sign_mask;
  logic [WORD_W-1:0] diff;
  logic              hit_s;

  // One extra bit is included so the sign bit itself survives the shift.
  assign sign_mask = ~({WORD_W{1'b1}} >> (amt + CNT_W'(1)));
  assign diff      = v ^ {WORD_W{v[WORD_W-1]}};
  assign hit_s     = ((diff & sign_mask) == '0);
  assign hit       = m ? hit_s : hit_u;
`else
  logic unused_m;
  assign unused_m = m;
  assign hit      = hit_u;
`endif

  assign v_next = hit ? (v << amt) : v;

endmodule

// File: rtl/normalizer_32.sv
// Multi-cycle 32-bit normalizer: one binary-search stage (16,8,4,2,1) per clock.
// NORMALIZER_SIGNED_EN enables the redundant-sign-bit mode selected by arith.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; last results held on outputs
// RUN     | stage index k counts 4..0, one shift decision per cycle
// DONE    | results just loaded, done pulses; start accepted here too
module normalizer_32
  import normalizer_32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  normalizer_32_if.slave  bus
);

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [WORD_W-1:0] v_q, v_d;
  logic [CNT_W-1:0]  c_q, c_d;
  logic              z_q, z_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              zero_q, zero_d;
  logic              m_q;
  logic              arith_eff;
  logic              accept;
  logic [WORD_W-1:0] v_nx;
  logic              hit;

  assign accept = bus.start && (state_q != ST_RUN);

`ifdef NORMALIZER_SIGNED_EN
  assign arith_eff = bus.arith;

  // Mode is captured together with the operand and held for the whole run.
  always_ff @(posedge clk) begin
    if (rst)         m_q <= 1'b0;
    else if (accept) m_q <= bus.arith;
  end
`else
  logic unused_arith;
  assign unused_arith = bus.arith;
  assign arith_eff    = 1'b0;
  assign m_q          = 1'b0;
`endif

  normalizer_32_stage u_stage (
    .v      (v_q),
    .k      (k_q),
    .m      (m_q),
    .v_next (v_nx),
    .hit    (hit)
  );

  // Next-state and datapath update; everything holds unless the state says otherwise.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    v_d     = v_q;
    c_d     = c_q;
    z_d     = z_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          v_d     = bus.x;
          c_d     = '0;
          z_d     = (bus.x == '0) && !arith_eff;
          k_d     = K_W'(NORM_STAGES - 1);
          state_d = ST_RUN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        v_d = v_nx;
        if (hit) c_d = c_q | (CNT_W'(1) << k_q);
        if (k_q == '0) begin
          state_d = ST_DONE;
          sh_d    = v_nx;
          // An all-zero unsigned operand reports the full word width.
          cnt_d   = z_q ? CNT_W'(WORD_W) : c_d;
          zero_d  = z_q;
        end else begin
          k_d = k_q - K_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset that drops any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      v_q     <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      v_q     <= v_d;
      c_q     <= c_d;
      z_q     <= z_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sh   = sh_q;
  assign bus.cnt  = cnt_q;
  assign bus.zero = zero_q;

endmodule

// File: doc/normalizer_32.md
# normalizer_32

Multi-cycle 32-bit normalizer: the inverse of the datapath barrel shifter. Given a word, it finds the shift amount that moves the most significant significant bit to bit 31 and returns both the amount and the normalized word. It serves count-leading-zeros/sign style instructions and software normalization in the CPU execute stage. It resolves one binary-search stage per clock (16, 8, 4, 2, 1), with a Start/Busy/Done handshake.

## Interface
Parameters:
- none; width (32) and stage count (5) are fixed package constants

Ports:
- Clk    in   1   rising-edge clock
- Rst    in   1   synchronous, active-high reset
- Start  in   1   request; sampled only while not Busy
- X      in   32  operand, captured on the accepted Start edge
- Arith  in   1   1 = count redundant sign bits (signed), 0 = count leading zeros; captured with X
- Busy   out  1   operation in progress
- Done   out  1   one-cycle pulse when results become valid
- Sh     out  32  normalized word
- Cnt    out  6   shift amount applied (0..32)
- Zero   out  1   operand was all zeros (unsigned mode only)

## Operation
- **States.** IDLE, RUN, DONE. A 3-bit stage index k counts 4 down to 0 in RUN.
- **Reset.** Rst → IDLE. Busy, Done, Zero = 0; Sh = 0; Cnt = 0. This applies mid-operation too, with no partial result kept.
- **Accepting a request.** IDLE or DONE with Start = 1:
  - load value register V ← X, count C ← 0, mode M ← Arith;
  - set Z ← (X == 0) && !Arith;
  - go to RUN with k = 4.
- **Unsigned step in RUN.** If V[31:32−2^k] is all zero: V ← V << 2^k (zero fill) and C[k] ← 1.
- **Signed step in RUN.** If V[31:31−2^k] (2^k+1 bits) are all equal to V[31]: V ← V << 2^k and C[k] ← 1.
- **Stage progression.** After k = 0, go to DONE.
- **Entering DONE.**
  - Sh ← V.
  - Cnt ← 32 if Z, else C.
  - Zero ← Z.
  - Done = 1 for exactly one cycle.
- **Holding results.** Sh, Cnt and Zero hold until the next accepted Start. They do not clear on leaving DONE.
- **Start while Busy.** Ignored with no side effect; X changes during RUN are ignored.
- **Start in the Done cycle.** Accepted (back-to-back issue). Results stay readable during that cycle.
- **DONE with no Start.** Returns to IDLE next edge.
- **Result ranges.**
  - Unsigned: X = 0 gives Sh = 0, Cnt = 32, Zero = 1. Otherwise Cnt = 0..31.
  - Signed: Cnt = 0..31. X = 0 and X = 0xFFFFFFFF both give Cnt = 31, and Zero is always 0.

## Timing
- Start is accepted at edge E0.
- Busy = 1 from after E0 through E5, i.e. 5 cycles.
- Done = 1 in the cycle after E5. Sh, Cnt and Zero are valid from that same cycle.
- Throughput is one operation per 6 cycles with back-to-back Start.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **NORMALIZER_SIGNED_EN defined:**
  - Arith is honoured;
  - the signed comparator (2^k+1-bit equality with V[31]) is built;
  - M is registered.
- **Not defined:**
  - the Arith port still exists but is ignored; M is tied to 0;
  - the signed path is removed;
  - behaviour is always leading-zero count.

## Structure
- **Shared package (cpu_pkg):**
  - word width 32;
  - NORM_STAGES = 5;
  - state encoding constants for IDLE/RUN/DONE;
  - count width 6.
- **Sub-module norm_stage.** Combinational; inputs V, k, M; outputs V_next, hit.
  - Contains the per-stage test and the shift mux.
  - The shift may reuse MUX2X32 for the shifted/unshifted select.
  - A single instance is time-multiplexed across the five stages.

## Test plan
- Arith = 0, X = 0x00010000 → Done 6 cycles after Start; Sh = 0x80000000, Cnt = 15, Zero = 0; Busy high exactly 5 cycles.
- Arith = 0, X = 0 → Sh = 0, Cnt = 32, Zero = 1. Then X = 0x80000000 → Cnt = 0, Sh = 0x80000000.
- Arith = 1 (macro on):
  - X = 0xFFFF0000 → Cnt = 15, Sh = 0x80000000;
  - X = 0x00000001 → Cnt = 30, Sh = 0x40000000;
  - X = 0xFFFFFFFF → Cnt = 31, Sh = 0x80000000.
- Back-to-back: second Start in the Done cycle with X = 0x00000001, Arith = 0 → first results readable that cycle; second Done 6 cycles later with Cnt = 31, Sh = 0x80000000. A Start pulsed mid-RUN → no extra Done.
- Rst asserted during stage k = 2 → next cycle IDLE; Busy = 0, Done = 0, Sh = 0, Cnt = 0. A subsequent Start completes normally.
- Macro off, Arith = 1, X = 0xFFFF0000 → treated as unsigned: Cnt = 0, Sh = 0xFFFF0000.
